// File: rtl/seq_pattern_tx_if.sv
// Serial pattern transmitter bus.
// Groups the start/abort handshake, the transfer configuration and the
// serial output stream of seq_pattern_tx.
//   start      request a transfer (honoured only while idle)
//   abort      synchronous cancel of any transfer in progress
//   rep_count  number of pattern repetitions, latched on an accepted start
//   gap_len    idle cycles between repetitions, latched on an accepted start
//   out        serial bit stream, MSB of the pattern first
//   frame      high while out carries a pattern bit
//   busy       high while a transfer is in progress
//   done       one-cycle completion pulse
// master: the controller side; slave: the transmitter.
interface seq_pattern_tx_if #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] rep_count;
    logic [GAP_W-1:0] gap_len;
    logic             out;
    logic             frame;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, rep_count, gap_len,
        input  out, frame, busy, done
    );

    modport slave (
        input  start, abort, rep_count, gap_len,
        output out, frame, busy, done
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter.
// Shifts PATTERN out MSB-first, one bit per clock, rep_count times with
// gap_len idle cycles between repetitions. Acts as the on-chip stimulus
// source for the serial sequence detectors.
//   clk  clock, rising edge
//   rst  synchronous active-high reset
//   bus  seq_pattern_tx_if slave: start/abort/rep_count/gap_len in,
//        out/frame/busy/done out (all outputs registered)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; out/frame/busy low
// SEND  | out carries PATTERN[bit_idx], frame and busy high
// GAP   | idle gap between repetitions; busy high, out/frame low
module seq_pattern_tx #(
    parameter int             PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int             CNT_W   = 8,
    parameter int             GAP_W   = 4
) (
    input  logic            clk,
    input  logic            rst,
    seq_pattern_tx_if.slave bus
);
    localparam int IDX_W = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]       state;
    logic [IDX_W-1:0] bit_idx;
    logic [CNT_W-1:0] reps_left;
    logic [GAP_W-1:0] gap_lat;
    logic [GAP_W-1:0] gap_cnt;
    logic             out_q;
    logic             frame_q;
    logic             busy_q;
    logic             done_q;

    assign bus.out   = out_q;
    assign bus.frame = frame_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

    always_ff @(posedge clk) begin
        if (rst || bus.abort) begin
            state     <= IDLE;
            bit_idx   <= '0;
            reps_left <= '0;
            gap_lat   <= '0;
            gap_cnt   <= '0;
            out_q     <= 1'b0;
            frame_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    out_q   <= 1'b0;
                    frame_q <= 1'b0;
                    busy_q  <= 1'b0;
                    if (bus.start) begin
                        reps_left <= bus.rep_count;
                        gap_lat   <= bus.gap_len;
                        if (bus.rep_count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state   <= SEND;
                            bit_idx <= IDX_MSB;
                            out_q   <= PATTERN[PAT_W-1];
                            frame_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end

                SEND: begin
                    if (bit_idx != '0) begin
                        bit_idx <= bit_idx - 1'b1;
                        out_q   <= PATTERN[bit_idx - 1'b1];
                    end else if (reps_left == CNT_W'(1)) begin
                        // last bit of last repetition just went out
                        state   <= IDLE;
                        out_q   <= 1'b0;
                        frame_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        reps_left <= reps_left - 1'b1;
                        if (gap_lat == '0) begin
                            // back-to-back: restart at the MSB with no bubble
                            bit_idx <= IDX_MSB;
                            out_q   <= PATTERN[PAT_W-1];
                        end else begin
                            state   <= GAP;
                            gap_cnt <= gap_lat;
                            out_q   <= 1'b0;
                            frame_q <= 1'b0;
                        end
                    end
                end

                GAP: begin
                    // down-counter: terminal count 1 marks the last gap cycle
                    if (gap_cnt == GAP_W'(1)) begin
                        state   <= SEND;
                        bit_idx <= IDX_MSB;
                        out_q   <= PATTERN[PAT_W-1];
                        frame_q <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    out_q   <= 1'b0;
                    frame_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter. Shifts a fixed PAT_W-bit pattern out MSB-first, one bit per clock, repeated a programmable number of times with a programmable idle gap between repetitions. It is the driving end of the serial bit-stream interface consumed by the Moore sequence detectors (e.g. the 1011 detector), so it serves as the on-chip stimulus source for them. A start/busy/done handshake controls it.

## Interface
- PAT_W, 4, pattern length in bits (≥2)
- PATTERN, 4'b1011, pattern transmitted MSB first
- CNT_W, 8, width of repetition counter
- GAP_W, 4, width of gap-length field
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset; synchronous, active-high
- start  input  1  request; sampled only in IDLE
- abort  input  1  synchronous cancel; same effect as rst on state and outputs
- rep_count  input  CNT_W  number of pattern repetitions; latched on accepted start
- gap_len  input  GAP_W  idle cycles between repetitions; latched on accepted start
- out  output  1  serial bit stream (connects to detector `in`)
- frame  output  1  high while `out` carries a pattern bit
- busy  output  1  high while a transfer is in progress
- done  output  1  one-cycle pulse at transfer completion

## Operation
- States: IDLE, SEND, GAP. All outputs are registered.
- Reset / abort: state=IDLE; out=0, frame=0, busy=0, done=0; bit index, rep and gap counters cleared. abort has priority over start. rst has priority over everything.
- IDLE: out=0, frame=0, busy=0. If start=1:
  - latch rep_count and gap_len;
  - if rep_count==0: stay IDLE, done<=1, no bits sent;
  - else: go to SEND with out<=PATTERN[PAT_W-1], frame<=1, busy<=1, bit index=PAT_W-1, reps remaining=rep_count.
- SEND: each cycle outputs PATTERN[index] and decrements index. After bit 0:
  - reps remaining==1: go to IDLE; out<=0, frame<=0, busy<=0, done<=1;
  - else decrement reps; if latched gap_len==0, go to the next pattern's MSB immediately (back-to-back); else go to GAP.
- GAP: out=0, frame=0, busy=1 for exactly gap_len cycles, then go to SEND at the MSB.
- start is ignored in SEND and GAP; rep_count and gap_len changes after acceptance have no effect.
- done is high only in the single cycle after the final bit (or after start when rep_count==0). It is otherwise 0.
- Counters do not wrap. The maximum transfer is (2^CNT_W−1) repetitions, with gap up to 2^GAP_W−1.

## Timing
- Start latency: start sampled at edge E0. The first pattern bit is on `out` in the cycle after E0.
- Transfer length with rep_count=R≥1 and gap_len=G: busy high for R·PAT_W + (R−1)·G cycles. done is high in the next cycle, and busy is 0 in that cycle.
- Example (default PATTERN, R=2, G=2, start at E0):
  - cycles 1–4: out=1,0,1,1 with frame=1;
  - cycles 5–6: out=0 with frame=0;
  - cycles 7–10: out=1,0,1,1;
  - cycle 11: done=1, busy=0.
- A start asserted in the done cycle is accepted (state is IDLE). busy rises the following cycle and done returns to 0.
- abort or rst mid-transfer: on the next cycle, out=0, frame=0, busy=0, done=0. No done pulse is generated for the aborted transfer.

## Test plan
- Reset: hold rst 2 cycles with start=1 -> out, frame, busy and done all 0; no transfer begins after rst drops until a new start.
- R=1, G=5, start pulse -> out=1,0,1,1 in cycles 1–4, frame=1 for those 4 cycles, done=1 in cycle 5, busy high for exactly 4 cycles.
- R=2, G=2 -> exact 11-cycle waveform above. When out feeds the 1011 detector, the detector asserts twice.
- R=2, G=0 -> out=1,0,1,1,1,0,1,1 contiguous, frame high 8 cycles, done in cycle 9.
- R=0 -> done=1 the cycle after start, busy and frame never high. Start pulses during busy of an R=3 transfer -> ignored; exactly 12 pattern bits are sent.
- abort in cycle 6 of an R=3, G=1 transfer -> outputs 0 from cycle 7, no done. A new start in cycle 8 -> a clean transfer from the MSB.
